am_envelope_demod: RTL and testbench

AM_ENVELOPE_DEMOD -- requirements
Module: am_envelope_demod

---
 rtl/pack_me.sv | 52 +++++
 rtl/moving_avg.sv | 86 ++++++++
 rtl/am_envelope_demod.sv | 141 ++++++++++++++
 tb/tb_am_envelope_demod.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pack_me.sv
// ---------------------------------------------------------------------------
// pack_me -- shared types for the AM demodulation path.
//
// Contents:
//   sig / msig       : baseband (16-bit) and modulated (32-bit) sample types
//   rect_t / env_t   : rectified magnitude (31-bit unsigned) and envelope
//                      (17-bit signed, always non-negative)
//   demod_state_t    : FILL / RUN state of the envelope demodulator
//   abs_clamp()      : |x| with the single unrepresentable case clamped
//   sat16()          : saturate an 18-bit difference to the sig range
// ---------------------------------------------------------------------------
package pack_me;

    typedef logic signed [15:0] sig;
    typedef logic signed [31:0] msig;

    localparam int RECT_W = 31;
    localparam int ENV_W  = 17;

    typedef logic        [RECT_W-1:0] rect_t;
    typedef logic signed [ENV_W-1:0]  env_t;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } demod_state_t;

    localparam rect_t RECT_MAX = {RECT_W{1'b1}};

    // Magnitude of a two's-complement sample. Only -2^31 has a magnitude
    // that needs bit 31, so that single case folds onto the largest value.
    function automatic rect_t abs_clamp(input msig x);
        logic [31:0] mag;
        mag = x[31] ? (~x + 32'd1) : x;
        if (mag[31]) begin
            return RECT_MAX;
        end
        return mag[RECT_W-1:0];
    endfunction

    // env - dc_int spans +/-65535, so 18 bits hold it exactly before clamping.
    function automatic sig sat16(input logic signed [17:0] x);
        if (x > 18'sd32767) begin
            return 16'sh7FFF;
        end
        if (x < -18'sd32768) begin
            return 16'sh8000;
        end
        return x[15:0];
    endfunction

endpackage

// File: rtl/moving_avg.sv
// ---------------------------------------------------------------------------
// moving_avg -- N-tap boxcar average of rectified samples, N = 2^LOG2_N.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset; clears buffer, sum, pointer
//   in_valid   : rect carries a new sample this cycle
//   rect       : rectified magnitude, 31-bit unsigned
//   avg_valid  : env reflects the sample accepted on the previous cycle
//   env        : (sum / N) >> 15, range 0..65535
//
// The running sum is updated in one step: subtract the slot about to be
// overwritten, add the incoming sample. Cycles without in_valid leave all
// state untouched.
// ---------------------------------------------------------------------------
module moving_avg
    import pack_me::*;
#(
    parameter int LOG2_N = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  in_valid,
    input  rect_t rect,
    output logic  avg_valid,
    output env_t  env
);

    localparam int N     = 1 << LOG2_N;
    localparam int ACC_W = RECT_W + LOG2_N;

    rect_t              slot_bus [N];
    logic [LOG2_N-1:0]  wr_ptr_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [ACC_W-1:0]   acc_next;
    logic               avg_valid_reg;
    rect_t              oldest;

    // One register per slot so every entry can be cleared by reset; only
    // the slot under the write pointer loads on an accepted sample.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot
            rect_t slot_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg <= '0;
                end else if (in_valid && (wr_ptr_reg == LOG2_N'(gi))) begin
                    slot_reg <= rect;
                end
            end

            assign slot_bus[gi] = slot_reg;
        end
    endgenerate

    assign oldest = slot_bus[wr_ptr_reg];

    // The oldest sample is part of the sum, so subtracting it first can
    // never underflow, and adding the new sample afterwards is bounded by
    // N*(2^31-1), which ACC_W bits hold exactly.
    always_comb begin
        acc_next = acc_reg - {{LOG2_N{1'b0}}, oldest};
        acc_next = acc_next + {{LOG2_N{1'b0}}, rect};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg       <= '0;
            wr_ptr_reg    <= '0;
            avg_valid_reg <= 1'b0;
        end else begin
            avg_valid_reg <= in_valid;
            if (in_valid) begin
                acc_reg    <= acc_next;
                // Power-of-two depth: natural wrap from N-1 to 0.
                wr_ptr_reg <= wr_ptr_reg + LOG2_N'(1);
            end
        end
    end

    assign avg_valid = avg_valid_reg;
    // Dividing by N and then by 2^15 leaves the top 16 bits of the sum.
    assign env       = {1'b0, acc_reg[ACC_W-1 -: 16]};

endmodule

// File: rtl/am_envelope_demod.sv
// ---------------------------------------------------------------------------
// am_envelope_demod -- envelope detector with DC removal for AM samples.
//
// Parameters:
//   LOG2_N    : log2 of the moving-average window (1..8)
//   DC_SHIFT  : time-constant shift of the DC tracker (1..15)
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : signal_in carries a new sample this cycle
//   signal_in  : modulated sample, 32-bit signed
//   out_valid  : one-cycle strobe, signal_out carries a new sample
//   signal_out : recovered baseband with DC removed; holds between strobes
//
// Pipeline (each stage advances only on its own valid):
//   1. rectify  -> rect_reg
//   2. boxcar   -> env (moving_avg)
//   3. DC track -> signal_out, dc_reg, FILL/RUN state
// A sample presented in cycle T appears on out_valid in cycle T+3.
// The first N samples after reset only fill the window; the Nth seeds the
// DC tracker with its own envelope and therefore emits 0.
// ---------------------------------------------------------------------------
module am_envelope_demod
    import pack_me::*;
#(
    parameter int LOG2_N   = 4,
    parameter int DC_SHIFT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  msig  signal_in,
    output logic out_valid,
    output sig   signal_out
);

    localparam int DC_W = ENV_W + DC_SHIFT;

    // ------------------------------------------------------------------
    // Stage 1: rectification
    // ------------------------------------------------------------------
    rect_t rect_reg;
    logic  rect_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rect_reg       <= '0;
            rect_valid_reg <= 1'b0;
        end else begin
            rect_valid_reg <= in_valid;
            if (in_valid) begin
                rect_reg <= abs_clamp(signal_in);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: moving average
    // ------------------------------------------------------------------
    logic avg_valid;
    env_t env;

    moving_avg #(
        .LOG2_N (LOG2_N)
    ) u_moving_avg (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rect_valid_reg),
        .rect      (rect_reg),
        .avg_valid (avg_valid),
        .env       (env)
    );

    // ------------------------------------------------------------------
    // Stage 3: DC tracker and FILL/RUN control
    // ------------------------------------------------------------------
    demod_state_t             state_reg;
    logic [LOG2_N-1:0]        fill_cnt_reg;
    logic signed [DC_W-1:0]   dc_reg;
    logic                     out_valid_reg;
    sig                       signal_out_reg;

    logic signed [DC_W-1:0]   env_shift;
    logic signed [ENV_W-1:0]  dc_int;
    logic signed [17:0]       diff;
    logic signed [DC_W-1:0]   delta;
    logic signed [DC_W-1:0]   dc_next;

    // dc always lies between its previous value and env << DC_SHIFT, both
    // non-negative and below 2^(DC_W-1); their difference and the updated
    // dc therefore fit in DC_W signed bits without wrapping.
    always_comb begin
        env_shift = {env, {DC_SHIFT{1'b0}}};
        dc_int    = dc_reg[DC_W-1:DC_SHIFT];
        diff      = {env[ENV_W-1], env} - {dc_int[ENV_W-1], dc_int};
        delta     = env_shift - dc_reg;
        dc_next   = dc_reg + (delta >>> DC_SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_FILL;
            fill_cnt_reg   <= '0;
            dc_reg         <= '0;
            out_valid_reg  <= 1'b0;
            signal_out_reg <= '0;
        end else begin
            out_valid_reg <= 1'b0;
            if (avg_valid) begin
                case (state_reg)
                    ST_FILL: begin
                        if (fill_cnt_reg == {LOG2_N{1'b1}}) begin
                            // Window now full: seed the tracker so the
                            // first output has no DC transient.
                            state_reg      <= ST_RUN;
                            fill_cnt_reg   <= '0;
                            dc_reg         <= env_shift;
                            signal_out_reg <= '0;
                            out_valid_reg  <= 1'b1;
                        end else begin
                            fill_cnt_reg <= fill_cnt_reg + LOG2_N'(1);
                        end
                    end
                    ST_RUN: begin
                        signal_out_reg <= sat16(diff);
                        dc_reg         <= dc_next;
                        out_valid_reg  <= 1'b1;
                    end
                    default: begin
                        state_reg <= ST_FILL;
                    end
                endcase
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign signal_out = signal_out_reg;

endmodule

// File: tb/tb_am_envelope_demod.sv
// ---------------------------------------------------------------------------
// tb_am_envelope_demod -- directed scoreboard bench for am_envelope_demod.
// The driver pushes {due cycle, expected value} for every sample that
// should produce output; the monitor pops on each out_valid.
// ---------------------------------------------------------------------------
module tb_am_envelope_demod;
    import pack_me::*;

    localparam int LOG2_N   = 4;
    localparam int N        = 1 << LOG2_N;
    localparam int DC_SHIFT = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    msig  signal_in;
    logic out_valid;
    sig   signal_out;

    always #5 clk = ~clk;

    am_envelope_demod #(
        .LOG2_N   (LOG2_N),
        .DC_SHIFT (DC_SHIFT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .signal_in  (signal_in),
        .out_valid  (out_valid),
        .signal_out (signal_out)
    );

    int     compared   = 0;
    int     mismatched = 0;
    longint cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint due;
        int     value;
    } exp_t;

    exp_t sb[$];

    // Observation statistics, reset per test.
    int out_count;
    int peak;
    int trough;
    int last_out;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    longint m_win [N];
    int     m_wp;
    longint m_sum;
    int     m_fill;
    bit     m_run;
    longint m_dc;

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_win[i] = 0;
        m_wp   = 0;
        m_sum  = 0;
        m_fill = 0;
        m_run  = 0;
        m_dc   = 0;
    endtask

    task automatic model_step(input msig x, output bit emits, output int val);
        longint r;
        longint env;
        longint dci;
        longint d;
        r = longint'(x);
        if (r < 0) r = -r;
        if (r > 64'sd2147483647) r = 64'sd2147483647;
        m_sum = m_sum - m_win[m_wp] + r;
        m_win[m_wp] = r;
        m_wp = (m_wp + 1) % N;
        env = (m_sum / N) / 32768;
        emits = 1'b0;
        val   = 0;
        if (!m_run) begin
            m_fill++;
            if (m_fill == N) begin
                m_run = 1'b1;
                m_dc  = env * (64'sd1 << DC_SHIFT);
                emits = 1'b1;
                val   = 0;
            end
        end else begin
            dci = m_dc / (64'sd1 << DC_SHIFT);
            d   = env - dci;
            if (d > 32767)  d = 32767;
            if (d < -32768) d = -32768;
            val   = int'(d);
            m_dc  = m_dc + ((env * (64'sd1 << DC_SHIFT) - m_dc) >>> DC_SHIFT);
            emits = 1'b1;
        end
    endtask

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input longint got, input longint want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic send(input bit v, input msig x);
        bit   e;
        int   val;
        exp_t item;
        @(posedge clk);
        #1;
        in_valid  = v;
        signal_in = v ? x : 32'sh1234_5678;
        if (v) begin
            model_step(x, e, val);
            if (e) begin
                item.due   = cyc + 3;
                item.value = val;
                sb.push_back(item);
            end
        end
    endtask

    task automatic drain(input string name);
        repeat (6) send(1'b0, 32'sh0);
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic start_test();
        out_count = 0;
        peak      = -100000;
        trough    = 100000;
        last_out  = 0;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_signal_out", signal_out, 0);
        sb.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    exp_t mon_item;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                out_count++;
                if (int'(signal_out) > peak)   peak   = int'(signal_out);
                if (int'(signal_out) < trough) trough = int'(signal_out);
                last_out = int'(signal_out);
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_output: got out_valid value %0d at cycle %0d, required none",
                             signal_out, cyc);
                end else begin
                    mon_item = sb.pop_front();
                    compared++;
                    if (signal_out !== sig'(mon_item.value)) begin
                        mismatched++;
                        $display("FAIL output_value: got %0d at cycle %0d, required %0d",
                                 signal_out, cyc, mon_item.value);
                    end
                    compared++;
                    if (cyc != mon_item.due) begin
                        mismatched++;
                        $display("FAIL output_latency: got cycle %0d, required cycle %0d",
                                 cyc, mon_item.due);
                    end
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                mon_item = sb.pop_front();
                compared++;
                mismatched++;
                $display("FAIL missing_output: got no out_valid by cycle %0d, required %0d at cycle %0d",
                         cyc, mon_item.value, mon_item.due);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        signal_in = '0;
        model_reset();
        start_test();

        #2 rst_n = 1'b0;
        #1;
        check("init_out_valid", out_valid, 0);
        check("init_signal_out", signal_out, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Constant +2^30: env 32768, 17 zero outputs from 32 samples.
        start_test();
        repeat (32) send(1'b1, 32'sh4000_0000);
        drain("drain_pos_const");
        check("pos_const_count", out_count, 17);
        check("pos_const_peak", peak, 0);
        check("pos_const_trough", trough, 0);

        // Constant -2^30: rectification symmetric.
        pulse_reset();
        start_test();
        repeat (32) send(1'b1, 32'shC000_0000);
        drain("drain_neg_const");
        check("neg_const_count", out_count, 17);
        check("neg_const_peak", peak, 0);
        check("neg_const_trough", trough, 0);

        // Constant -2^31: clamp path, env 65535.
        pulse_reset();
        start_test();
        repeat (32) send(1'b1, 32'sh8000_0000);
        drain("drain_min_const");
        check("min_const_count", out_count, 17);
        check("min_const_peak", peak, 0);
        check("min_const_trough", trough, 0);

        // Step 2^30 -> 1.5*2^30: ramp to just under 16384, then decay.
        pulse_reset();
        start_test();
        repeat (16) send(1'b1, 32'sh4000_0000);
        repeat (80) send(1'b1, 32'sh6000_0000);
        drain("drain_step");
        check("step_count", out_count, 81);
        check("step_peak_in_range", (peak >= 15500 && peak <= 16384), 1);
        check("step_decays", (last_out < peak - 1000 && last_out > 0), 1);

        // Same step with in_valid pattern 1,0,0,1,0.
        pulse_reset();
        start_test();
        for (int i = 0; i < 40; i++) begin
            send(1'b1, (i < 16) ? 32'sh4000_0000 : 32'sh6000_0000);
            send(1'b0, 32'sh0);
            if ((i % 2) == 0) send(1'b0, 32'sh0);
        end
        drain("drain_gapped");
        check("gapped_count", out_count, 25);

        // Full-scale drop: negative saturation.
        pulse_reset();
        start_test();
        repeat (16) send(1'b1, 32'sh8000_0000);
        repeat (24) send(1'b1, 32'sh0);
        drain("drain_neg_sat");
        check("neg_sat_trough", trough, -32768);

        // Full-scale rise: positive saturation.
        pulse_reset();
        start_test();
        repeat (16) send(1'b1, 32'sh0);
        repeat (24) send(1'b1, 32'sh7FFF_FFFF);
        drain("drain_pos_sat");
        check("pos_sat_peak", peak, 32767);

        // Reset pulse mid-RUN, then refill with a different level.
        pulse_reset();
        start_test();
        repeat (20) send(1'b1, 32'sh4000_0000);
        pulse_reset();
        start_test();
        repeat (20) send(1'b1, 32'sh5000_0000);
        drain("drain_mid_reset");
        check("mid_reset_count", out_count, 5);
        check("mid_reset_peak", peak, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
